cluster_frame_builder: RTL and testbench

CLUSTER_FRAME_BUILDER -- requirements
Module: cluster_frame_builder

---
 rtl/cluster_frame_builder.sv | 78 +++++++
 tb/tb_cluster_frame_builder.sv | 113 +++++++++++
 2 files changed

// File: rtl/cluster_frame_builder.sv
// cluster_frame_builder: packs priority-encoder clusters into per-bunch-crossing frames.
// Optional CLUSTER_OVF_COUNT_EN builds a saturating dropped-cluster counter.
module cluster_frame_builder #(
  parameter int MXCLUSTERS = 8,
  parameter int MXADRB     = 9,
  parameter int MXCNTB     = 3
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       bx_strobe,
  input  logic                                       vpf_i,
  input  logic [MXADRB-1:0]                          adr_i,
  input  logic [MXCNTB-1:0]                          cnt_i,
  output logic [MXCLUSTERS*(MXADRB+MXCNTB)-1:0]      clusters_o,
  output logic [$clog2(MXCLUSTERS+1)-1:0]            nclusters_o,
  output logic                                       valid_o,
  output logic                                       overflow_o,
  output logic [15:0]                                ovf_count_o
);
  localparam int W  = MXADRB + MXCNTB;
  localparam int PW = $clog2(MXCLUSTERS + 1);
  localparam logic [W-1:0] EMPTY = {{MXCNTB{1'b0}}, {MXADRB{1'b1}}};
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_nx;
  logic [W-1:0] slot [MXCLUSTERS];
  logic [PW-1:0] wr_ptr;
  logic ovf, close, full;
  logic [W-1:0] data;
  always_ff @(posedge clock) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = bx_strobe ? COLLECT : state;
    close    = (state == COLLECT) && bx_strobe;
    full     = wr_ptr == PW'(MXCLUSTERS);
    data     = {cnt_i, adr_i};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < MXCLUSTERS; k++) begin
        slot[k]              <= EMPTY;
        clusters_o[k*W +: W] <= EMPTY;
      end
      wr_ptr      <= '0;
      ovf         <= 1'b0;
      nclusters_o <= '0;
      valid_o     <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      valid_o <= close;
      if (close) begin
        for (int k = 0; k < MXCLUSTERS; k++) clusters_o[k*W +: W] <= slot[k];
        nclusters_o <= wr_ptr;
        overflow_o  <= ovf;
      end
      if (bx_strobe) begin
        for (int k = 1; k < MXCLUSTERS; k++) slot[k] <= EMPTY;
        slot[0] <= vpf_i ? data : EMPTY;
        wr_ptr  <= vpf_i ? PW'(1) : PW'(0);
        ovf     <= 1'b0;
      end else if (state == COLLECT && vpf_i) begin
        if (full) ovf <= 1'b1;
        else begin
          for (int k = 0; k < MXCLUSTERS; k++) if (wr_ptr == PW'(k)) slot[k] <= data;
          wr_ptr <= wr_ptr + PW'(1);
        end
      end
    end
  end
`ifdef CLUSTER_OVF_COUNT_EN
  logic [15:0] ovf_cnt;
  always_ff @(posedge clock) begin
    if (reset) ovf_cnt <= '0;
    else if (state == COLLECT && vpf_i && !bx_strobe && full && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
  end
  assign ovf_count_o = ovf_cnt;
`else
  assign ovf_count_o = '0;
`endif
endmodule

// File: tb/tb_cluster_frame_builder.sv
// tb_cluster_frame_builder: directed + random frames checked against a queue-based frame model.
module tb_cluster_frame_builder;
  logic clock = 0, reset = 1, bx_strobe = 0, vpf_i = 0;
  logic [8:0] adr_i = 0;
  logic [2:0] cnt_i = 0;
  logic [95:0] clusters_o;
  logic [3:0] nclusters_o;
  logic valid_o, overflow_o;
  logic [15:0] ovf_count_o;
  int tests = 0, fails = 0;
  logic [11:0] q[$];
  bit started, ovf, e_valid, e_ovf;
  int unsigned drops, e_n;
  logic [95:0] e_clu;

  cluster_frame_builder dut (
    .clock(clock), .reset(reset), .bx_strobe(bx_strobe), .vpf_i(vpf_i),
    .adr_i(adr_i), .cnt_i(cnt_i), .clusters_o(clusters_o), .nclusters_o(nclusters_o),
    .valid_o(valid_o), .overflow_o(overflow_o), .ovf_count_o(ovf_count_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] pack_frame();
    logic [95:0] r;
    for (int k = 0; k < 8; k++) r[k*12 +: 12] = (k < q.size()) ? q[k] : 12'h1FF;
    return r;
  endfunction

  task automatic step(input bit rs, input bit st, input bit v, input logic [8:0] a, input logic [2:0] c);
    reset = rs; bx_strobe = st; vpf_i = v; adr_i = a; cnt_i = c;
    @(posedge clock);
    if (rs) begin
      started = 0; q.delete(); ovf = 0; drops = 0;
      e_valid = 0; e_n = 0; e_ovf = 0; e_clu = {8{12'h1FF}};
    end else begin
      e_valid = started && st;
      if (e_valid) begin e_clu = pack_frame(); e_n = q.size(); e_ovf = ovf; end
      if (st) begin
        q.delete();
        if (v) q.push_back({c, a});
        ovf = 0; started = 1;
      end else if (started && v) begin
        if (q.size() < 8) q.push_back({c, a});
        else begin ovf = 1; if (drops < 65535) drops++; end
      end
    end
    #1;
    chk("valid", valid_o, e_valid);
    chk("nclusters", nclusters_o, e_n);
    chk("overflow", overflow_o, e_ovf);
    chk("clusters", clusters_o, e_clu);
`ifdef CLUSTER_OVF_COUNT_EN
    chk("ovf_count", ovf_count_o, drops);
`else
    chk("ovf_count", ovf_count_o, 0);
`endif
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // three hits then close
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 5, 1);
    step(0, 0, 1, 12, 0);
    step(0, 0, 1, 300, 7);
    step(0, 1, 0, 0, 0);
    chk("f3_n", nclusters_o, 3);
    chk("f3_slot2", clusters_o[35:24], {3'd7, 9'd300});
    chk("f3_slot3", clusters_o[47:36], 12'h1FF);
    // ten hits overflow
    for (int i = 0; i < 10; i++) step(0, 0, 1, 9'(20 + i), 3'(i));
    step(0, 1, 0, 0, 0);
    chk("ovf_n", nclusters_o, 8);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_slot7", clusters_o[95:84], {3'd7, 9'd27});
    // hit coincident with strobe
    step(0, 0, 1, 1, 1);
    step(0, 1, 1, 7, 2);
    chk("coinc_n", nclusters_o, 1);
    step(0, 1, 0, 0, 0);
    chk("coinc_slot0", clusters_o[11:0], {3'd2, 9'd7});
    // hits before first strobe, mid-frame reset
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 3, 3);
    step(0, 0, 1, 4, 4);
    step(0, 1, 0, 0, 0);
    chk("first_strobe_novalid", valid_o, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 9'(40 + i), 1);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("rst_frame_n", nclusters_o, 0);
    // back-to-back strobes
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 9'(i), 3'(i));
    // random
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
           9'($urandom), 3'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
